// File: rtl/pool_ctrl.sv
// Pooling-layer job controller.
// Streams one or more square feature-map channels out of a read RAM into an
// external 2x2 pooling unit, and writes the pooled results into a result RAM.
// A single FSM sequences IDLE -> RUN -> DRAIN -> DONE. A watchdog aborts the
// drain when the pooling unit stops producing results.
module pool_ctrl #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          mode,
  input  logic [3:0]    nch,
  input  logic          stall,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          pool_state,
  output logic          pool_ivalid,
  output logic [7:0]    pool_din,
  input  logic          pool_ovalid,
  input  logic [7:0]    pool_dout,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // Read counter covers 15 * 576 = 8640 reads, output counter 15 * 144 = 2160.
  localparam int unsigned RCW = 14;
  localparam int unsigned OCW = 12;
  // Idle DRAIN cycles tolerated before the job is declared stuck.
  localparam logic [4:0] WdLimit = 5'd30;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e         state_q;
  logic           mode_q;
  logic [3:0]     nch_q;
  logic [RCW-1:0] rd_cnt_q;
  logic [OCW-1:0] out_cnt_q;
  logic [4:0]     wd_cnt_q;
  logic           ivalid_q;
  logic           err_q;

  logic           in_job;
  logic [RCW-1:0] tot_rd;
  logic [OCW-1:0] tot_out;
  logic           last_rd;
  logic           last_out;

  // Job geometry derived from the channel count and map size latched at start.
  always_comb begin
    tot_rd   = RCW'(nch_q) * (mode_q ? RCW'(64) : RCW'(576));
    tot_out  = OCW'(nch_q) * (mode_q ? OCW'(16) : OCW'(144));
    last_rd  = (rd_cnt_q == tot_rd - RCW'(1));
    last_out = (out_cnt_q + OCW'(1) == tot_out);
  end

  // Strobes and status decoded from registered state; write path is
  // deliberately combinational so a pooled result lands in the same cycle.
  always_comb begin
    in_job      = (state_q == StRun) || (state_q == StDrain);
    rd_en       = (state_q == StRun) && !stall;
    rd_addr     = AW'(rd_cnt_q);
    pool_ivalid = ivalid_q;
    // RAM data is only meaningful the cycle after a read; hold 0 otherwise.
    pool_din    = ivalid_q ? rd_data : 8'h00;
    pool_state  = mode_q;
    wr_en       = in_job && pool_ovalid;
    wr_addr     = AW'(out_cnt_q);
    wr_data     = wr_en ? pool_dout : 8'h00;
    busy        = in_job;
    done        = (state_q == StDone);
    err         = err_q;
  end

  // Job sequencing, address/output counters and drain watchdog.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      nch_q     <= 4'd0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      wd_cnt_q  <= '0;
      ivalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ivalid_q <= rd_en;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mode_q    <= mode;
            nch_q     <= nch;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_cnt_q  <= '0;
            state_q   <= (nch == 4'd0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (rd_en) begin
            rd_cnt_q <= rd_cnt_q + RCW'(1);
            if (last_rd) begin
              wd_cnt_q <= '0;
              state_q  <= StDrain;
            end
          end
          if (pool_ovalid) begin
            out_cnt_q <= out_cnt_q + OCW'(1);
          end
        end
        StDrain: begin
          if (pool_ovalid) begin
            out_cnt_q <= out_cnt_q + OCW'(1);
            wd_cnt_q  <= '0;
            if (last_out) begin
              state_q <= StDone;
            end
          end else if (wd_cnt_q == WdLimit) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            wd_cnt_q <= wd_cnt_q + 5'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
